frame_read_ctrl: RTL and testbench

- Per-channel read sequencer that sits in front of one requester port of the 4-channel read arbiter (chN_rd_burst_*).
- On each frame_start it splits a frame of frame_len words at frame_base_addr into bursts of at most BURST_LEN words.
- It issues each burst only when the downstream display read FIFO has room for the whole burst.
- It forwards returned data into that FIFO and reports frame completion and length errors.

---
 rtl/frame_read_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_frame_read_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_read_ctrl.sv
// Per-channel frame read sequencer: splits a frame into FIFO-sized bursts for one
// read-arbiter requester port and forwards the returned words into the display FIFO.
module frame_read_ctrl #(
  parameter int MEM_DATA_BITS = 32,
  parameter int BURST_LEN     = 128,
  parameter int FIFO_DEPTH    = 512,
  parameter int FIFO_AW       = 9
) (
  input  logic                     mem_clk,
  input  logic                     rst_n,
  input  logic                     frame_start,
  input  logic [23:0]              frame_base_addr,
  input  logic [23:0]              frame_len,
  input  logic [FIFO_AW:0]         fifo_usedw,
  output logic                     fifo_wr_en,
  output logic [MEM_DATA_BITS-1:0] fifo_wr_data,
  output logic                     rd_burst_req,
  output logic [9:0]               rd_burst_len,
  output logic [23:0]              rd_burst_addr,
  input  logic                     rd_burst_data_valid,
  input  logic [MEM_DATA_BITS-1:0] rd_burst_data,
  input  logic                     rd_burst_finish,
  output logic                     frame_busy,
  output logic                     frame_done,
  output logic                     len_err
);

  typedef enum logic [1:0] {IDLE, WAIT_SPACE, REQ, DONE} state_t;

  state_t                   state_q, state_d;
  logic [23:0]              remaining_q, remaining_d;
  logic [23:0]              nextAddr_q, nextAddr_d;
  logic [10:0]              wordCnt_q, wordCnt_d;
  logic                     req_q, req_d;
  logic [9:0]               burstLen_q, burstLen_d;
  logic [23:0]              burstAddr_q, burstAddr_d;
  logic                     wrEn_q, wrEn_d;
  logic [MEM_DATA_BITS-1:0] wrData_q, wrData_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     lenErr_q, lenErr_d;
  logic                     pend_q, pend_d;
  logic [23:0]              pendBase_q, pendBase_d;
  logic [23:0]              pendLen_q, pendLen_d;

  logic [9:0]  curLen;
  logic [31:0] freeWords;
  logic        spaceOk;
  logic        accGo;
  logic [23:0] accBase;
  logic [23:0] accLen;
  logic [23:0] newRemaining;

  // Burst size is capped by BURST_LEN; usedw above depth is treated as a full FIFO.
  always_comb begin
    curLen = (remaining_q >= 24'(BURST_LEN)) ? 10'(BURST_LEN) : remaining_q[9:0];
    freeWords = 32'(FIFO_DEPTH) - 32'(fifo_usedw);
    spaceOk = (32'(fifo_usedw) <= 32'(FIFO_DEPTH)) && (freeWords >= 32'(curLen));
    newRemaining = remaining_q - 24'(burstLen_q);
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    nextAddr_d  = nextAddr_q;
    wordCnt_d   = wordCnt_q;
    req_d       = req_q;
    burstLen_d  = burstLen_q;
    burstAddr_d = burstAddr_q;
    wrEn_d      = 1'b0;
    wrData_d    = wrData_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    lenErr_d    = lenErr_q;
    pend_d      = pend_q;
    pendBase_d  = pendBase_q;
    pendLen_d   = pendLen_q;
    accGo       = 1'b0;
    accBase     = frame_base_addr;
    accLen      = frame_len;

    case (state_q)
      IDLE: accGo = frame_start;

      WAIT_SPACE: begin
        if (frame_start) begin
          accGo = 1'b1;
        end else if (spaceOk) begin
          burstLen_d  = curLen;
          burstAddr_d = nextAddr_q;
          req_d       = 1'b1;
          wordCnt_d   = '0;
          state_d     = REQ;
        end
      end

      REQ: begin
        if (rd_burst_data_valid) begin
          wordCnt_d = wordCnt_q + 11'd1;
          wrEn_d    = 1'b1;
          wrData_d  = rd_burst_data;
        end
        // A burst already granted cannot be cancelled, so a new frame waits for its finish.
        if (frame_start && !rd_burst_finish) begin
          pend_d     = 1'b1;
          pendBase_d = frame_base_addr;
          pendLen_d  = frame_len;
        end
        if (rd_burst_finish) begin
          req_d       = 1'b0;
          nextAddr_d  = nextAddr_q + 24'(burstLen_q);
          remaining_d = newRemaining;
          if ((wordCnt_q + 11'(rd_burst_data_valid)) != {1'b0, burstLen_q}) begin
            lenErr_d = 1'b1;
          end
          if (frame_start || pend_q) begin
            accGo   = 1'b1;
            accBase = frame_start ? frame_base_addr : pendBase_q;
            accLen  = frame_start ? frame_len : pendLen_q;
          end else if (newRemaining == 24'd0) begin
            state_d = DONE;
          end else begin
            state_d = WAIT_SPACE;
          end
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
        accGo   = frame_start;
      end

      default: state_d = IDLE;
    endcase

    // Accepting a frame abandons whatever frame was running, including its frame_done.
    if (accGo) begin
      lenErr_d = 1'b0;
      pend_d   = 1'b0;
      done_d   = 1'b0;
      if (accLen != 24'd0) begin
        nextAddr_d  = accBase;
        remaining_d = accLen;
        busy_d      = 1'b1;
        state_d     = WAIT_SPACE;
      end else begin
        busy_d  = 1'b0;
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge mem_clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      nextAddr_q  <= '0;
      wordCnt_q   <= '0;
      req_q       <= 1'b0;
      burstLen_q  <= '0;
      burstAddr_q <= '0;
      wrEn_q      <= 1'b0;
      wrData_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      lenErr_q    <= 1'b0;
      pend_q      <= 1'b0;
      pendBase_q  <= '0;
      pendLen_q   <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      nextAddr_q  <= nextAddr_d;
      wordCnt_q   <= wordCnt_d;
      req_q       <= req_d;
      burstLen_q  <= burstLen_d;
      burstAddr_q <= burstAddr_d;
      wrEn_q      <= wrEn_d;
      wrData_q    <= wrData_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      lenErr_q    <= lenErr_d;
      pend_q      <= pend_d;
      pendBase_q  <= pendBase_d;
      pendLen_q   <= pendLen_d;
    end
  end

  assign fifo_wr_en    = wrEn_q;
  assign fifo_wr_data  = wrData_q;
  assign rd_burst_req  = req_q;
  assign rd_burst_len  = burstLen_q;
  assign rd_burst_addr = burstAddr_q;
  assign frame_busy    = busy_q;
  assign frame_done    = done_q;
  assign len_err       = lenErr_q;

endmodule

// File: tb/tb_frame_read_ctrl.sv
// Directed bench for frame_read_ctrl: a small arbiter model serves bursts while
// monitors tally FIFO writes and frame_done pulses against hand-computed values.
module tb_frame_read_ctrl;

  logic        mem_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [23:0] frame_base_addr = '0;
  logic [23:0] frame_len = '0;
  logic [9:0]  fifo_usedw = '0;
  logic        fifo_wr_en;
  logic [31:0] fifo_wr_data;
  logic        rd_burst_req;
  logic [9:0]  rd_burst_len;
  logic [23:0] rd_burst_addr;
  logic        rd_burst_data_valid = 1'b0;
  logic [31:0] rd_burst_data = '0;
  logic        rd_burst_finish = 1'b0;
  logic        frame_busy;
  logic        frame_done;
  logic        len_err;

  int total = 0;
  int bad = 0;
  int wrCount = 0;
  int wrSum = 0;
  int doneCount = 0;
  int dataCtr = 0;
  int mark;

  frame_read_ctrl #(
    .MEM_DATA_BITS(32), .BURST_LEN(128), .FIFO_DEPTH(512), .FIFO_AW(9)
  ) dut (
    .mem_clk(mem_clk), .rst_n(rst_n), .frame_start(frame_start),
    .frame_base_addr(frame_base_addr), .frame_len(frame_len), .fifo_usedw(fifo_usedw),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .rd_burst_req(rd_burst_req),
    .rd_burst_len(rd_burst_len), .rd_burst_addr(rd_burst_addr),
    .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_data(rd_burst_data),
    .rd_burst_finish(rd_burst_finish), .frame_busy(frame_busy), .frame_done(frame_done),
    .len_err(len_err)
  );

  always #5 mem_clk = ~mem_clk;

  always @(posedge mem_clk) begin
    #1;
    if (fifo_wr_en) begin
      wrCount++;
      wrSum += int'(fifo_wr_data);
    end
    if (frame_done) doneCount++;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge mem_clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [23:0] base, input logic [23:0] len);
    frame_start = 1'b1;
    frame_base_addr = base;
    frame_len = len;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic waitReq(input string tag);
    for (int i = 0; i < 100 && !rd_burst_req; i++) tick();
    checkOutput({tag, "_reqSeen"}, 32'(rd_burst_req), 32'd1);
  endtask

  // Arbiter model: grant after two cycles, stream nWords, then one finish pulse.
  task automatic serveBurst(input int nWords, input logic [23:0] expAddr,
                            input logic [9:0] expLen, input string tag);
    waitReq(tag);
    if (!rd_burst_req) return;
    checkOutput({tag, "_addr"}, 32'(rd_burst_addr), 32'(expAddr));
    checkOutput({tag, "_len"}, 32'(rd_burst_len), 32'(expLen));
    repeat (2) tick();
    for (int i = 0; i < nWords; i++) begin
      rd_burst_data_valid = 1'b1;
      rd_burst_data = 32'(dataCtr);
      dataCtr++;
      tick();
    end
    rd_burst_data_valid = 1'b0;
    rd_burst_finish = 1'b1;
    tick();
    rd_burst_finish = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    checkOutput("rst_req", 32'(rd_burst_req), 32'd0);
    checkOutput("rst_busy", 32'(frame_busy), 32'd0);
    checkOutput("rst_done", 32'(frame_done), 32'd0);
    checkOutput("rst_lenErr", 32'(len_err), 32'd0);
    checkOutput("rst_wrEn", 32'(fifo_wr_en), 32'd0);
    checkOutput("rst_len", 32'(rd_burst_len), 32'd0);
    checkOutput("rst_addr", 32'(rd_burst_addr), 32'd0);
    rst_n = 1'b1;
    tick();

    // 300-word frame: two full bursts and a 44-word tail.
    applyStimulus(24'h001000, 24'd300);
    checkOutput("f1_busy", 32'(frame_busy), 32'd1);
    serveBurst(128, 24'h001000, 10'd128, "f1b0");
    serveBurst(128, 24'h001080, 10'd128, "f1b1");
    serveBurst(44, 24'h001100, 10'd44, "f1b2");
    checkOutput("f1_reqLow", 32'(rd_burst_req), 32'd0);
    checkOutput("f1_doneEarly", 32'(frame_done), 32'd0);
    tick();
    checkOutput("f1_done", 32'(frame_done), 32'd1);
    checkOutput("f1_busyLow", 32'(frame_busy), 32'd0);
    tick();
    checkOutput("f1_doneOnce", 32'(frame_done), 32'd0);
    checkOutput("f1_wrCount", 32'(wrCount), 32'd300);
    checkOutput("f1_wrSum", 32'(wrSum), 32'd44850);
    checkOutput("f1_lenErr", 32'(len_err), 32'd0);

    // FIFO space gating: 112 free blocks a 128 burst, exactly 128 free allows it.
    fifo_usedw = 10'd400;
    applyStimulus(24'h002000, 24'd128);
    repeat (5) tick();
    checkOutput("sp_blocked", 32'(rd_burst_req), 32'd0);
    fifo_usedw = 10'd384;
    repeat (2) tick();
    checkOutput("sp_req", 32'(rd_burst_req), 32'd1);
    serveBurst(128, 24'h002000, 10'd128, "sp");
    repeat (3) tick();
    fifo_usedw = 10'd0;

    // Zero-length frame: no request, frame_done two cycles after frame_start.
    mark = doneCount;
    applyStimulus(24'h000000, 24'd0);
    checkOutput("z_done1", 32'(frame_done), 32'd0);
    tick();
    checkOutput("z_done2", 32'(frame_done), 32'd1);
    checkOutput("z_req", 32'(rd_burst_req), 32'd0);
    tick();
    checkOutput("z_doneCount", 32'(doneCount - mark), 32'd1);

    // Restart while a burst is in flight: old burst finishes, new frame takes over.
    applyStimulus(24'h001000, 24'd300);
    waitReq("rs");
    mark = doneCount;
    applyStimulus(24'h000000, 24'd256);
    serveBurst(128, 24'h001000, 10'd128, "rs0");
    serveBurst(128, 24'h000000, 10'd128, "rs1");
    serveBurst(128, 24'h000080, 10'd128, "rs2");
    repeat (3) tick();
    checkOutput("rs_doneCount", 32'(doneCount - mark), 32'd1);
    checkOutput("rs_busy", 32'(frame_busy), 32'd0);

    // Short burst flags len_err, the frame still completes, next start clears it.
    applyStimulus(24'h003000, 24'd256);
    serveBurst(127, 24'h003000, 10'd128, "le0");
    checkOutput("le_set", 32'(len_err), 32'd1);
    serveBurst(128, 24'h003080, 10'd128, "le1");
    repeat (3) tick();
    checkOutput("le_sticky", 32'(len_err), 32'd1);
    applyStimulus(24'h005000, 24'd0);
    checkOutput("le_clear", 32'(len_err), 32'd0);
    repeat (3) tick();

    // Reset in the middle of a data stream.
    applyStimulus(24'h004000, 24'd128);
    waitReq("rr");
    for (int i = 0; i < 5; i++) begin
      rd_burst_data_valid = 1'b1;
      rd_burst_data = 32'(dataCtr);
      dataCtr++;
      tick();
    end
    rst_n = 1'b0;
    tick();
    checkOutput("rr_req", 32'(rd_burst_req), 32'd0);
    checkOutput("rr_wrEn", 32'(fifo_wr_en), 32'd0);
    checkOutput("rr_busy", 32'(frame_busy), 32'd0);
    checkOutput("rr_len", 32'(rd_burst_len), 32'd0);
    checkOutput("rr_addr", 32'(rd_burst_addr), 32'd0);
    rst_n = 1'b1;
    mark = wrCount;
    repeat (4) tick();
    checkOutput("rr_noWrite", 32'(wrCount - mark), 32'd0);
    checkOutput("rr_reqIdle", 32'(rd_burst_req), 32'd0);
    rd_burst_data_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
